// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_pkg                                                              |
// | Shared state encodings and default timing constants for the I2C      |
// | transaction arbiter.                                                 |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package i2c_pkg;

  typedef logic [1:0] req_vec_t;

  localparam logic [2:0] C_ST_IDLE  = 3'd0;
  localparam logic [2:0] C_ST_LOAD  = 3'd1;
  localparam logic [2:0] C_ST_RUN   = 3'd2;
  localparam logic [2:0] C_ST_DRAIN = 3'd3;
  localparam logic [2:0] C_ST_DONE  = 3'd4;

  localparam int C_TIMEOUT_DEF  = 1023;
  localparam int C_STOP_GAP_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter2                                                          |
// | Two-way round-robin pick; last = index of the previously granted     |
// | requester.                                                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter2
  import i2c_pkg::*;
(
  input  req_vec_t req,
  input  logic     last,
  output req_vec_t winner
);

  always_comb begin
    winner = req;
    if (req == 2'b11) begin
      winner = last ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | i2c_txn_arbiter                                                      |
// | Arbitrates two requesters onto one I2C engine, sequencing each       |
// | transaction with a byte watchdog and a STOP drain gap.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int LEN_W    = 4,
  parameter int TIMEOUT  = C_TIMEOUT_DEF,
  parameter int STOP_GAP = C_STOP_GAP_DEF
) (
  input  logic             core_clk,
  input  logic             rst_n,
  input  req_vec_t         req,
  input  logic [7:0]       req_addr0,
  input  logic [7:0]       req_addr1,
  input  logic [LEN_W-1:0] req_len0,
  input  logic [LEN_W-1:0] req_len1,
  input  logic             byte_done,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic             enable,
  output logic [7:0]       slave_address,
  output logic             busy
);

  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (STOP_GAP > 1) ? $clog2(STOP_GAP) : 1;

  logic [2:0]       r_state;
  logic [1:0]       r_grant;
  logic [7:0]       r_addr;
  logic [LEN_W-1:0] r_remaining;
  logic [WD_W-1:0]  r_wd;
  logic [GAP_W-1:0] r_gap;
  logic             r_enable;
  logic             r_err_pend;
  logic             r_last;
  req_vec_t         w_winner;

  rr_arbiter2 u_rr (
    .req    (req),
    .last   (r_last),
    .winner (w_winner)
  );

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= C_ST_IDLE;
      r_grant     <= 2'b00;
      r_addr      <= 8'h00;
      r_remaining <= '0;
      r_wd        <= '0;
      r_gap       <= '0;
      r_enable    <= 1'b0;
      r_err_pend  <= 1'b0;
      r_last      <= 1'b1;
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          if (|req) begin
            r_grant     <= w_winner;
            r_addr      <= w_winner[1] ? req_addr1 : req_addr0;
            r_remaining <= w_winner[1] ? req_len1 : req_len0;
            r_err_pend  <= 1'b0;
            r_state     <= C_ST_LOAD;
          end
        end
        C_ST_LOAD: begin
          r_wd <= '0;
          if (r_remaining == '0) begin
            r_state <= C_ST_DONE;
          end else begin
            r_enable <= 1'b1;
            r_state  <= C_ST_RUN;
          end
        end
        C_ST_RUN: begin
          // A byte completing in the timeout cycle wins over the abort
          if (byte_done) begin
            r_wd <= '0;
            if (r_remaining != '0) begin
              r_remaining <= r_remaining - LEN_W'(1);
            end
            if (r_remaining == LEN_W'(1)) begin
              r_enable <= 1'b0;
              r_gap    <= '0;
              r_state  <= C_ST_DRAIN;
            end
          end else if (r_wd == WD_W'(TIMEOUT)) begin
            r_enable   <= 1'b0;
            r_err_pend <= 1'b1;
            r_gap      <= '0;
            r_state    <= C_ST_DRAIN;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        C_ST_DRAIN: begin
          if (r_gap == GAP_W'(STOP_GAP - 1)) begin
            r_state <= C_ST_DONE;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        C_ST_DONE: begin
          r_last     <= r_grant[1];
          r_grant    <= 2'b00;
          r_err_pend <= 1'b0;
          r_state    <= C_ST_IDLE;
        end
        default: begin
          r_state <= C_ST_IDLE;
        end
      endcase
    end
  end

  assign grant         = r_grant;
  assign enable        = r_enable;
  assign slave_address = r_addr;
  assign busy          = (r_state != C_ST_IDLE);
  assign done          = (r_state == C_ST_DONE) ? r_grant : 2'b00;
  assign err           = ((r_state == C_ST_DONE) && r_err_pend) ? r_grant : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_i2c_txn_arbiter                                                   |
// | Directed plus randomized transactions checked cycle by cycle against |
// | a transaction-level model of the arbiter.                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_i2c_txn_arbiter;

  localparam int TIMEOUT  = 1023;
  localparam int STOP_GAP = 16;

  logic       core_clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [7:0] req_addr0, req_addr1;
  logic [3:0] req_len0, req_len1;
  logic       byte_done;
  logic [1:0] grant, done, err;
  logic       enable;
  logic [7:0] slave_address;
  logic       busy;

  int         n_cmp  = 0;
  int         n_fail = 0;
  bit         last_m;
  int         gap_q[16];
  logic [1:0] r_rq;
  logic [7:0] r_a0, r_a1;
  logic [3:0] r_l0, r_l1;

  i2c_txn_arbiter #(.LEN_W(4), .TIMEOUT(TIMEOUT), .STOP_GAP(STOP_GAP)) dut (
    .core_clk      (core_clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_addr0     (req_addr0),
    .req_addr1     (req_addr1),
    .req_len0      (req_len0),
    .req_len1      (req_len1),
    .byte_done     (byte_done),
    .grant         (grant),
    .done          (done),
    .err           (err),
    .enable        (enable),
    .slave_address (slave_address),
    .busy          (busy)
  );

  always #5 core_clk = ~core_clk;

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] eg, input logic een,
                         input logic [1:0] edn, input logic [1:0] eer, input logic ebusy,
                         input logic [7:0] eaddr, input bit chk_addr);
    chk({tag, "_grant"},  {30'd0, grant}, {30'd0, eg});
    chk({tag, "_enable"}, {31'd0, enable}, {31'd0, een});
    chk({tag, "_done"},   {30'd0, done}, {30'd0, edn});
    chk({tag, "_err"},    {30'd0, err}, {30'd0, eer});
    chk({tag, "_busy"},   {31'd0, busy}, {31'd0, ebusy});
    if (chk_addr) chk({tag, "_addr"}, {24'd0, slave_address}, {24'd0, eaddr});
  endtask

  task automatic scramble_inputs();
    req       = 2'($urandom);
    req_addr0 = 8'($urandom);
    req_addr1 = 8'($urandom);
    req_len0  = 4'($urandom);
    req_len1  = 4'($urandom);
  endtask

  // Transaction model: gap_q[b] quiet cycles precede byte b; more than TIMEOUT aborts
  task automatic run_txn(input string tag, input logic [1:0] rq, input logic [7:0] a0,
                         input logic [7:0] a1, input logic [3:0] l0, input logic [3:0] l1,
                         input bit scramble);
    logic [1:0] w;
    logic [7:0] ea;
    int         len;
    bit         aborted;
    if (rq == 2'b11) w = last_m ? 2'b01 : 2'b10;
    else             w = rq;
    ea  = w[1] ? a1 : a0;
    len = w[1] ? int'(l1) : int'(l0);
    aborted = 1'b0;
    chk({tag, "_pre_idle"}, {31'd0, busy}, 32'd0);
    req = rq; req_addr0 = a0; req_addr1 = a1; req_len0 = l0; req_len1 = l1;
    byte_done = 1'b0;
    tick();
    chk_out({tag, "_load"}, w, 1'b0, 2'b00, 2'b00, 1'b1, ea, 1'b1);
    if (scramble) scramble_inputs();
    tick();
    if (len != 0) begin
      for (int b = 0; b < len && !aborted; b++) begin
        int q;
        q = (gap_q[b] > TIMEOUT) ? TIMEOUT + 1 : gap_q[b];
        for (int c = 0; c < q; c++) begin
          chk_out({tag, "_run"}, w, 1'b1, 2'b00, 2'b00, 1'b1, ea, 1'b1);
          if (scramble) scramble_inputs();
          tick();
        end
        if (gap_q[b] > TIMEOUT) begin
          aborted = 1'b1;
        end else begin
          chk_out({tag, "_run_pulse"}, w, 1'b1, 2'b00, 2'b00, 1'b1, ea, 1'b1);
          byte_done = 1'b1;
          tick();
          byte_done = 1'b0;
        end
      end
      for (int c = 0; c < STOP_GAP; c++) begin
        chk_out({tag, "_drain"}, w, 1'b0, 2'b00, 2'b00, 1'b1, ea, 1'b1);
        byte_done = 1'($urandom_range(0, 1));
        tick();
      end
      byte_done = 1'b0;
    end
    chk_out({tag, "_done"}, w, 1'b0, w, aborted ? w : 2'b00, 1'b1, ea, 1'b1);
    tick();
    last_m = w[1];
    chk_out({tag, "_idle"}, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, ea, 1'b0);
    req = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; req = 2'b00; byte_done = 1'b0;
    req_addr0 = 8'h00; req_addr1 = 8'h00; req_len0 = 4'd0; req_len1 = 4'd0;
    last_m = 1'b1;
    for (int i = 0; i < 16; i++) gap_q[i] = 0;
    repeat (3) tick();
    chk_out("reset", 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b1);
    rst_n = 1'b1;
    tick();

    // Three bytes to requester 0
    gap_q[0] = 0; gap_q[1] = 2; gap_q[2] = 1;
    run_txn("three_bytes", 2'b01, 8'hA0, 8'h11, 4'd3, 4'd9, 1'b1);

    // Both requesting, single bytes: requester 1 then requester 0 alternate
    gap_q[0] = 1;
    run_txn("rr_first", 2'b11, 8'h52, 8'h3B, 4'd1, 4'd1, 1'b0);
    run_txn("rr_second", 2'b11, 8'h52, 8'h3B, 4'd1, 4'd1, 1'b0);
    run_txn("rr_third", 2'b11, 8'h64, 8'hC7, 4'd1, 4'd1, 1'b0);

    // One byte then silence on requester 1
    gap_q[0] = 0; gap_q[1] = TIMEOUT + 1;
    run_txn("timeout", 2'b10, 8'h22, 8'hB5, 4'd7, 4'd2, 1'b1);

    // Zero-length transfer
    run_txn("zero_len", 2'b01, 8'h4C, 8'h99, 4'd0, 4'd5, 1'b1);

    // Last byte lands exactly when the watchdog hits TIMEOUT
    gap_q[0] = TIMEOUT;
    run_txn("edge_wd", 2'b01, 8'h90, 8'h10, 4'd1, 4'd1, 1'b0);

    // Reset in the middle of a run
    req = 2'b10; req_addr1 = 8'h77; req_len1 = 4'd5;
    tick(); tick(); tick();
    chk("mid_rst_pre_enable", {31'd0, enable}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("mid_rst_async", 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b1);
    req = 2'b00;
    tick();
    rst_n = 1'b1;
    last_m = 1'b1;
    for (int c = 0; c < STOP_GAP + 4; c++) begin
      tick();
      chk_out("mid_rst_quiet", 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    end
    gap_q[0] = 0;
    run_txn("post_rst", 2'b11, 8'h1E, 8'hE1, 4'd1, 4'd1, 1'b0);

    // Randomized transactions
    for (int t = 0; t < 30; t++) begin
      r_rq = 2'($urandom_range(1, 3));
      r_a0 = 8'($urandom); r_a1 = 8'($urandom);
      r_l0 = 4'($urandom_range(0, 6)); r_l1 = 4'($urandom_range(0, 6));
      for (int i = 0; i < 16; i++) begin
        gap_q[i] = ($urandom_range(0, 19) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 3));
      end
      run_txn("random", r_rq, r_a0, r_a1, r_l0, r_l1, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
